// File: rtl/dvfs_pkg.sv
// Shared types, constants and the load saturation helper for the DVFS load monitor.
package dvfs_pkg;

  localparam int LOAD_W = 16;

  typedef logic [LOAD_W-1:0] load_t;
  typedef logic [1:0]        alpha_t;

  localparam load_t LOAD_MAX = 16'hFFFF;

  // Clamp a signed intermediate into the unsigned 16-bit load range.
  function automatic load_t sat_load(input logic signed [18:0] v);
    if (v < 0)             return '0;
    if (v > 19'sd65535)    return LOAD_MAX;
    return v[LOAD_W-1:0];
  endfunction

endpackage

// File: rtl/dvfs_load_monitor_load_ema_filter.sv
// One utilisation channel: window busy counter, scaling to 16 bits, EMA step and clamp.
// With DVFS_LOAD_PEAK_EN the pre-register EMA result is exported for peak tracking.
module load_ema_filter
  import dvfs_pkg::*;
#(
  parameter int WINDOW_LOG2 = 8
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   busy_i,
  input  logic   window_end_i,
  input  logic   enable_i,
  input  alpha_t alpha_shift_i,
  output load_t  load_o
`ifdef DVFS_LOAD_PEAK_EN
  ,
  output load_t  load_nxt_o
`endif
);

  localparam int CW = WINDOW_LOG2 + 1;

  logic [CW-1:0]      cnt_q, cnt_d, total;
  logic [16:0]        raw_ext;
  load_t              raw, load_q, load_d, load_upd;
  logic signed [17:0] diff, step;
  logic signed [18:0] sum;

  // The busy flag of the closing cycle still belongs to the window being closed.
  assign total   = cnt_q + CW'(busy_i);
  assign raw_ext = 17'(total) << (LOAD_W - WINDOW_LOG2);
  assign raw     = sat_load(signed'({2'b00, raw_ext}));

  assign diff     = signed'({2'b00, raw}) - signed'({2'b00, load_q});
  assign step     = diff >>> alpha_shift_i;
  assign sum      = signed'({step[17], step}) + signed'({3'b000, load_q});
  assign load_upd = sat_load(sum);

  always_comb begin
    cnt_d  = total;
    load_d = load_q;
    if (!enable_i || window_end_i) cnt_d = '0;
    if (window_end_i)              load_d = load_upd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      load_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      load_q <= load_d;
    end
  end

  assign load_o = load_q;
`ifdef DVFS_LOAD_PEAK_EN
  assign load_nxt_o = load_upd;
`endif

endmodule

// File: rtl/dvfs_load_monitor.sv
// DVFS load monitor top: window counter, per-channel EMA filters and load_valid pulse.
// Optional feature macro: DVFS_LOAD_PEAK_EN adds peak_load / peak_idx over the core channels.
module dvfs_load_monitor
  import dvfs_pkg::*;
#(
  parameter int NUM_CORES          = 4,
  parameter int LOAD_MONITOR_WIDTH = 16,
  parameter int WINDOW_LOG2        = 8
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          enable,
  input  alpha_t                                        alpha_shift,
  input  logic [NUM_CORES-1:0]                          core_busy,
  input  logic                                          mem_busy,
  input  logic                                          noc_busy,
  input  logic                                          ai_busy,
  output logic [NUM_CORES-1:0][LOAD_MONITOR_WIDTH-1:0]  core_load,
  output logic [LOAD_MONITOR_WIDTH-1:0]                 memory_load,
  output logic [LOAD_MONITOR_WIDTH-1:0]                 noc_load,
  output logic [LOAD_MONITOR_WIDTH-1:0]                 ai_accel_load,
  output logic                                          load_valid
`ifdef DVFS_LOAD_PEAK_EN
  ,
  output logic [LOAD_MONITOR_WIDTH-1:0]                 peak_load,
  output logic [$clog2(NUM_CORES)-1:0]                  peak_idx
`endif
);

  logic [WINDOW_LOG2-1:0] wcnt_q, wcnt_d;
  logic                   valid_q;
  logic                   window_end;
  load_t [NUM_CORES-1:0]  core_q;
  load_t [2:0]            misc_q;
  logic  [2:0]            misc_busy;

  assign window_end = enable && (&wcnt_q);
  assign wcnt_d     = enable ? wcnt_q + 1'b1 : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      wcnt_q  <= wcnt_d;
      valid_q <= window_end;
    end
  end

`ifdef DVFS_LOAD_PEAK_EN
  localparam int IW = $clog2(NUM_CORES);
  load_t [NUM_CORES-1:0] core_nxt;
`endif

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    load_ema_filter #(.WINDOW_LOG2(WINDOW_LOG2)) u_flt (
      .clk           (clk),
      .rst_n         (rst_n),
      .busy_i        (core_busy[i]),
      .window_end_i  (window_end),
      .enable_i      (enable),
      .alpha_shift_i (alpha_shift),
      .load_o        (core_q[i])
`ifdef DVFS_LOAD_PEAK_EN
      ,
      .load_nxt_o    (core_nxt[i])
`endif
    );
  end

  assign misc_busy = {ai_busy, noc_busy, mem_busy};

  for (genvar i = 0; i < 3; i++) begin : g_misc
    load_ema_filter #(.WINDOW_LOG2(WINDOW_LOG2)) u_flt (
      .clk           (clk),
      .rst_n         (rst_n),
      .busy_i        (misc_busy[i]),
      .window_end_i  (window_end),
      .enable_i      (enable),
      .alpha_shift_i (alpha_shift),
      .load_o        (misc_q[i])
`ifdef DVFS_LOAD_PEAK_EN
      ,
      .load_nxt_o    ()
`endif
    );
  end

  assign core_load     = core_q;
  assign memory_load   = misc_q[0];
  assign noc_load      = misc_q[1];
  assign ai_accel_load = misc_q[2];
  assign load_valid    = valid_q;

`ifdef DVFS_LOAD_PEAK_EN
  load_t           peak_q, peak_d;
  logic [IW-1:0]   idx_q, idx_d;

  // Strict compare keeps the lowest index on ties.
  always_comb begin
    peak_d = peak_q;
    idx_d  = idx_q;
    if (window_end) begin
      peak_d = core_nxt[0];
      idx_d  = '0;
      for (int i = 1; i < NUM_CORES; i++) begin
        if (core_nxt[i] > peak_d) begin
          peak_d = core_nxt[i];
          idx_d  = IW'(i);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_q <= '0;
      idx_q  <= '0;
    end else begin
      peak_q <= peak_d;
      idx_q  <= idx_d;
    end
  end

  assign peak_load = peak_q;
  assign peak_idx  = idx_q;
`endif

endmodule

// File: tb/tb_dvfs_load_monitor.sv
// Directed bench for dvfs_load_monitor: table of per-window vectors plus enable-gap,
// saturation/decay and asynchronous-reset sequences (peak checks with DVFS_LOAD_PEAK_EN).
module tb_dvfs_load_monitor;
  localparam int NC = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                enable;
  logic [1:0]          alpha_shift;
  logic [NC-1:0]       core_busy;
  logic                mem_busy, noc_busy, ai_busy;
  logic [NC-1:0][15:0] core_load;
  logic [15:0]         memory_load, noc_load, ai_accel_load;
  logic                load_valid;
`ifdef DVFS_LOAD_PEAK_EN
  logic [15:0]         peak_load;
  logic [1:0]          peak_idx;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dvfs_load_monitor #(.NUM_CORES(NC), .LOAD_MONITOR_WIDTH(16), .WINDOW_LOG2(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .alpha_shift   (alpha_shift),
    .core_busy     (core_busy),
    .mem_busy      (mem_busy),
    .noc_busy      (noc_busy),
    .ai_busy       (ai_busy),
    .core_load     (core_load),
    .memory_load   (memory_load),
    .noc_load      (noc_load),
    .ai_accel_load (ai_accel_load),
    .load_valid    (load_valid)
`ifdef DVFS_LOAD_PEAK_EN
    ,
    .peak_load     (peak_load),
    .peak_idx      (peak_idx)
`endif
  );

  // Channel order in every record: {ai, noc, mem, core3, core2, core1, core0}.
  typedef struct packed {
    logic [1:0]        alpha;
    logic [6:0][8:0]   n;    // busy cycles at the start of the 256-cycle window
    logic [6:0][15:0]  e;    // loads expected right after the window closes
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] ld(input int ch);
    if (ch < NC)  return core_load[ch];
    if (ch == 4)  return memory_load;
    if (ch == 5)  return noc_load;
    return ai_accel_load;
  endfunction

  task automatic set_busy(input logic [6:0] b);
    core_busy = b[3:0];
    mem_busy  = b[4];
    noc_busy  = b[5];
    ai_busy   = b[6];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_loads(input string tag, input vec_t v);
    for (int ch = 0; ch < 7; ch++)
      chk($sformatf("%s_ch%0d", tag, ch), 32'(ld(ch)), 32'(v.e[ch]));
  endtask

  task automatic run_window(input string tag, input vec_t v);
    logic [6:0] b;
    logic       early;
    early = 1'b0;
    enable = 1'b1;
    alpha_shift = v.alpha;
    for (int cyc = 0; cyc < 256; cyc++) begin
      for (int ch = 0; ch < 7; ch++) b[ch] = (cyc < int'(v.n[ch]));
      set_busy(b);
      step();
      if (cyc < 255) early |= load_valid;
    end
    chk({tag, "_valid"}, 32'(load_valid), 32'd1);
    chk({tag, "_early_valid"}, 32'(early), 32'd0);
    check_loads(tag, v);
  endtask

  initial begin
    vec_t v;
    logic gap_valid, gap_hold;

    tbl[0].alpha = 2'd0;
    tbl[0].n = {9'd0,   9'd64,  9'd128, 9'd0, 9'd0,   9'd0,   9'd256};
    tbl[0].e = {16'h0000, 16'h4000, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF};
    tbl[1].alpha = 2'd2;
    tbl[1].n = {9'd128, 9'd64,  9'd128, 9'd1, 9'd0,   9'd128, 9'd0};
    tbl[1].e = {16'h2000, 16'h4000, 16'h8000, 16'h0040, 16'h0000, 16'h2000, 16'hBFFF};
    tbl[2].alpha = 2'd2;
    tbl[2].n = {9'd128, 9'd256, 9'd0,   9'd1, 9'd255, 9'd128, 9'd0};
    tbl[2].e = {16'h3800, 16'h6FFF, 16'h6000, 16'h0070, 16'h3FC0, 16'h3800, 16'h8FFF};
    tbl[3].alpha = 2'd2;
    tbl[3].n = {9'd128, 9'd0,   9'd0,   9'd0, 9'd0,   9'd128, 9'd0};
    tbl[3].e = {16'h4A00, 16'h53FF, 16'h4800, 16'h0054, 16'h2FD0, 16'h4A00, 16'h6BFF};
    tbl[4].alpha = 2'd3;
    tbl[4].n = {9'd0,   9'd0,   9'd0,   9'd0, 9'd0,   9'd256, 9'd256};
    tbl[4].e = {16'h40C0, 16'h497F, 16'h3F00, 16'h0049, 16'h29D6, 16'h60BF, 16'h7E7F};

    rst_n = 1'b0;
    enable = 1'b0;
    alpha_shift = 2'd0;
    set_busy(7'h7F);
    step();
    step();
    for (int ch = 0; ch < 7; ch++) chk($sformatf("reset_ch%0d", ch), 32'(ld(ch)), 32'd0);
    chk("reset_valid", 32'(load_valid), 32'd0);
`ifdef DVFS_LOAD_PEAK_EN
    chk("reset_peak", 32'(peak_load), 32'd0);
    chk("reset_peak_idx", 32'(peak_idx), 32'd0);
`endif
    rst_n = 1'b1;
    step();

    for (int w = 0; w < 5; w++) run_window($sformatf("tbl%0d", w), tbl[w]);

    // Partial window then an enable gap: partial counts must be discarded.
    gap_valid = 1'b0;
    gap_hold  = 1'b0;
    enable = 1'b1;
    alpha_shift = 2'd0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      set_busy(7'b0000010);
      step();
    end
    for (int cyc = 0; cyc < 50; cyc++) begin
      enable = 1'b0;
      set_busy(7'h7F);
      step();
      gap_valid |= load_valid;
      gap_hold  |= (core_load[0] !== 16'h7E7F) || (core_load[1] !== 16'h60BF);
    end
    chk("gap_valid", 32'(gap_valid), 32'd0);
    chk("gap_hold", 32'(gap_hold), 32'd0);
    v = '0;
    v.n[0] = 9'd256;
    v.e[0] = 16'hFFFF;
    run_window("reenable", v);

    // Saturate every channel, then decay with alpha=1 down to and holding at 0.
    v.alpha = 2'd0;
    for (int ch = 0; ch < 7; ch++) begin
      v.n[ch] = 9'd256;
      v.e[ch] = 16'hFFFF;
    end
    run_window("full", v);
    v.alpha = 2'd1;
    v.n = '0;
    for (int k = 1; k <= 17; k++) begin
      for (int ch = 0; ch < 7; ch++) v.e[ch] = 16'(32'hFFFF >> k);
      run_window($sformatf("decay%0d", k), v);
    end

    v = '0;
    v.n[0] = 9'd64;  v.e[0] = 16'h4000;
    v.n[1] = 9'd144; v.e[1] = 16'h9000;
    v.n[3] = 9'd144; v.e[3] = 16'h9000;
    run_window("peak", v);
`ifdef DVFS_LOAD_PEAK_EN
    chk("peak_load", 32'(peak_load), 32'h9000);
    chk("peak_idx", 32'(peak_idx), 32'd1);
`endif

    // Reset asserted between clock edges at window cycle 200.
    for (int cyc = 0; cyc < 200; cyc++) begin
      set_busy(7'h7F);
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    for (int ch = 0; ch < 7; ch++) chk($sformatf("async_rst_ch%0d", ch), 32'(ld(ch)), 32'd0);
    chk("async_rst_valid", 32'(load_valid), 32'd0);
`ifdef DVFS_LOAD_PEAK_EN
    chk("async_rst_peak", 32'(peak_load), 32'd0);
    chk("async_rst_peak_idx", 32'(peak_idx), 32'd0);
`endif
    step();
    rst_n = 1'b1;
    v = '0;
    v.n[0] = 9'd256;
    v.e[0] = 16'hFFFF;
    run_window("post_rst", v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dvfs_load_monitor.md
Name: dvfs_load_monitor

Overview:
Upstream feeder of the power manager's DVFS governor. It converts per-core busy indications and memory/NoC/AI-accelerator activity strobes into 16-bit utilisation values. Conversion uses a fixed sampling window followed by a per-channel exponential moving average (EMA). Its outputs drive core_load, memory_load, noc_load and ai_accel_load directly; a load_valid pulse marks each update.

Parameters:
NUM_CORES, 4, number of CPU core channels
LOAD_MONITOR_WIDTH, 16, width of every load value (fixed 16; others unsupported)
WINDOW_LOG2, 8, sampling window = 2^WINDOW_LOG2 clk cycles; legal 1..16

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  monitoring enable
alpha_shift  in  2  EMA smoothing shift 0..3 (0 = no smoothing)
core_busy  in  NUM_CORES  per-cycle busy flag per core
mem_busy  in  1  per-cycle memory controller busy
noc_busy  in  1  per-cycle NoC busy
ai_busy  in  1  per-cycle AI accelerator busy
core_load  out  NUM_CORES x 16  filtered per-core load
memory_load  out  16  filtered memory load
noc_load  out  16  filtered NoC load
ai_accel_load  out  16  filtered AI load
load_valid  out  1  one-cycle pulse when loads update

Behaviour:
- Channels: NUM_CORES + 3, identical datapath.
- Reset: all loads 0, load_valid 0, window counter 0, busy counters 0.
- Window counter: WINDOW_LOG2 bits, increments every cycle while enable=1. The last cycle is count == 2^WINDOW_LOG2-1; the counter wraps to 0 on the next cycle.
- Busy counters: WINDOW_LOG2+1 bits; +1 on each enabled cycle with busy=1.
  - Busy sampled in the last window cycle counts toward that window.
  - On wrap, counters restart at 0, or at 1 if busy in the first cycle of the new window.
- End of window (edge closing the last cycle):
  - raw = busy_cnt << (16-WINDOW_LOG2), clamped to 0xFFFF (full window gives 0x10000, clamped to 0xFFFF).
  - diff = raw - load_old, 18-bit signed.
  - load_new = load_old + (diff >>> alpha_shift), arithmetic shift (floor), clamped to [0, 0xFFFF].
  - load_new is registered on that same edge; load_valid is high for exactly the following cycle.
  - Latency: loads are visible 1 cycle after the last window cycle.
- alpha_shift is sampled at each update edge only; changes mid-window take effect at the next update.
- enable=0:
  - window and busy counters are synchronously cleared;
  - loads hold their last value;
  - load_valid=0.
  - Deasserting mid-window discards the partial window. Re-enabling starts a fresh window at count 0.
- Reset mid-window: immediate clear of all state and outputs, independent of clk.
- Busy inputs are assumed synchronous to clk; no CDC inside the block.

Optional Feature:
Macro DVFS_LOAD_PEAK_EN.
- Defined: adds outputs peak_load (16) and peak_idx ($clog2(NUM_CORES)). Both are registered on the same update edge as the loads.
  - peak_load = maximum core_load_new across cores; peak_idx = its index, lowest index on ties.
  - Both reset to 0 and hold while enable=0.
- Undefined: the ports and the logic do not exist.

Decomposition:
- Package dvfs_pkg holds:
  - LOAD_W=16 and typedef load_t (logic [15:0]);
  - typedef alpha_t (logic [1:0]);
  - LOAD_MAX = 16'hFFFF;
  - function sat_load() performing the clamp.
- Sub-module load_ema_filter, instantiated once per channel:
  - inputs busy, window_end, enable, alpha_shift;
  - output load_t;
  - owns the busy counter, scaling, EMA and clamp.
- The top level owns the window counter, the load_valid pulse and the optional peak logic.

Test Plan:
1. WINDOW_LOG2=8, alpha=0, core_busy[0]=1 for all 256 cycles -> core_load[0]=0xFFFF, load_valid high 1 cycle after cycle 255, other cores 0.
2. alpha=0, mem_busy high for 128 of 256 cycles -> memory_load=0x8000.
3. alpha=2, ai_busy 50% over consecutive windows from 0 -> ai_accel_load 0x2000, then 0x3800, then 0x4A00.
4. Loads at 0xFFFF, alpha=1, busy=0 for one window -> load 0x7FFF; no negative wrap, clamp holds at 0 after further idle windows.
5. enable dropped at cycle 100 and raised 50 cycles later, then 256 full-busy cycles -> no load_valid during the gap, single update to 0xFFFF (alpha=0), prior values held meanwhile.
6. rst_n asserted at window cycle 200 -> all outputs 0 asynchronously. With DVFS_LOAD_PEAK_EN and cores 1 and 3 both at 0x9000 -> peak_load=0x9000, peak_idx=1.
